mel_accumulator: RTL and testbench

MEL_ACCUMULATOR -- requirements
Module: mel_accumulator

---
 rtl/mel_accumulator.sv | 130 +++++++++++++
 tb/tb_mel_accumulator.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mel_accumulator.sv
// Mel band accumulator: sums groups of BINS_PER_BAND magnitude bins into
// saturating band energies and queues them in a NUM_BANDS-deep output FIFO.
module mel_accumulator #(
    parameter int unsigned NUM_BINS  = 256,
    parameter int unsigned NUM_BANDS = 16,
    parameter int unsigned IN_WIDTH  = 32,
    parameter int unsigned OUT_WIDTH = 32,
    localparam int unsigned BINS_PER_BAND = NUM_BINS / NUM_BANDS,
    localparam int unsigned IDX_W = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IN_WIDTH-1:0]  mag_in,
    input  logic                 mag_valid,
    input  logic                 mag_sof,
    output logic                 mag_ready,
    output logic [OUT_WIDTH-1:0] band_out,
    output logic [IDX_W-1:0]     band_idx,
    output logic                 band_valid,
    input  logic                 band_ready,
    output logic                 frame_done,
    output logic                 overflow
);

    localparam int unsigned CNT_W = $clog2(NUM_BINS) + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]           state;
    logic [OUT_WIDTH-1:0] acc;
    logic [CNT_W-1:0]     bin_cnt;

    logic [OUT_WIDTH-1:0] fifo_data [NUM_BANDS];
    logic [IDX_W-1:0]     fifo_idx  [NUM_BANDS];
    logic [IDX_W-1:0]     wr_ptr;
    logic [IDX_W-1:0]     rd_ptr;
    logic [IDX_W:0]       count;

    logic                 fifo_full;
    logic                 take_mag;
    logic                 take_band;
    logic                 in_frame;
    logic                 start;
    logic [CNT_W-1:0]     pos;
    logic [OUT_WIDTH-1:0] base;
    logic [OUT_WIDTH:0]   sum_wide;
    logic [OUT_WIDTH-1:0] sum_sat;
    logic                 band_end;
    logic                 frame_end;
    logic [IDX_W-1:0]     wr_idx;

    // A sof bin restarts the frame at position 0 from either IDLE or ACCUM,
    // so the datapath sees one unified "in-frame bin" with a computed position.
    always_comb begin
        fifo_full = (32'(count) == NUM_BANDS);
        mag_ready = 1'b0;
        unique case (state)
            IDLE:    mag_ready = 1'b1;
            ACCUM:   mag_ready = !fifo_full;
            default: mag_ready = 1'b0;
        endcase

        band_valid = (count != '0);
        band_out   = band_valid ? fifo_data[rd_ptr] : '0;
        band_idx   = band_valid ? fifo_idx[rd_ptr]  : '0;
        take_band  = band_valid && band_ready;
        frame_done = take_band && (32'(band_idx) == NUM_BANDS - 1);

        take_mag  = mag_valid && mag_ready;
        start     = take_mag && mag_sof;
        in_frame  = take_mag && (mag_sof || (state == ACCUM));
        pos       = start ? '0 : bin_cnt;
        base      = start ? '0 : acc;
        sum_wide  = {1'b0, base} + (OUT_WIDTH + 1)'(mag_in);
        sum_sat   = sum_wide[OUT_WIDTH] ? '1 : sum_wide[OUT_WIDTH-1:0];
        band_end  = in_frame && ((32'(pos) % BINS_PER_BAND) == BINS_PER_BAND - 1);
        frame_end = in_frame && (32'(pos) == NUM_BINS - 1);
        wr_idx    = IDX_W'(32'(pos) / BINS_PER_BAND);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            acc      <= '0;
            bin_cnt  <= '0;
            overflow <= 1'b0;
        end else begin
            if (in_frame) begin
                acc      <= band_end ? '0 : sum_sat;
                bin_cnt  <= frame_end ? '0 : pos + CNT_W'(1);
                state    <= frame_end ? DRAIN : ACCUM;
                if (sum_wide[OUT_WIDTH]) begin
                    overflow <= 1'b1;
                end
            end else if ((state == DRAIN) && (count == '0)) begin
                state <= IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (band_end) begin
                wr_ptr <= wr_ptr + IDX_W'(1);
            end
            if (take_band) begin
                rd_ptr <= rd_ptr + IDX_W'(1);
            end
            unique case ({band_end, take_band})
                2'b10:   count <= count + (IDX_W + 1)'(1);
                2'b01:   count <= count - (IDX_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (band_end) begin
            fifo_data[wr_ptr] <= sum_sat;
            fifo_idx[wr_ptr]  <= wr_idx;
        end
    end

endmodule

// File: tb/tb_mel_accumulator.sv
// Directed testbench for mel_accumulator (256 bins, 16 bands of 16 bins).
module tb_mel_accumulator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] mag_in = '0;
    logic        mag_valid = 1'b0;
    logic        mag_sof = 1'b0;
    logic        mag_ready;
    logic [31:0] band_out;
    logic [3:0]  band_idx;
    logic        band_valid;
    logic        band_ready = 1'b0;
    logic        frame_done;
    logic        overflow;

    int checks = 0;
    int failures = 0;
    int ready_mode = 0;  // 0 = hold low, 1 = hold high, 2 = random
    int fd_cnt = 0;
    logic [31:0] cap_out [$];
    logic [3:0]  cap_idx [$];
    logic        stalled = 1'b0;
    logic [31:0] held_out;
    logic [3:0]  held_idx;

    mel_accumulator #(
        .NUM_BINS(256),
        .NUM_BANDS(16),
        .IN_WIDTH(32),
        .OUT_WIDTH(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mag_in(mag_in),
        .mag_valid(mag_valid),
        .mag_sof(mag_sof),
        .mag_ready(mag_ready),
        .band_out(band_out),
        .band_idx(band_idx),
        .band_valid(band_valid),
        .band_ready(band_ready),
        .frame_done(frame_done),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        if (ready_mode == 2) band_ready = ($urandom_range(0, 1) == 1);
        else                 band_ready = (ready_mode == 1);
    end

    // Band capture and stall-stability monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (stalled && band_valid) begin
                checks++;
                if (band_out !== held_out || band_idx !== held_idx) begin
                    failures++;
                    $display("FAIL stall_hold got=%h/%0d exp=%h/%0d", band_out, band_idx, held_out, held_idx);
                end
            end
            if (band_valid && band_ready) begin
                cap_out.push_back(band_out);
                cap_idx.push_back(band_idx);
            end
            if (frame_done === 1'b1) fd_cnt++;
            stalled  = band_valid && !band_ready;
            held_out = band_out;
            held_idx = band_idx;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst = 1'b1; mag_valid = 1'b0; mag_sof = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        cap_out.delete(); cap_idx.delete(); fd_cnt = 0;
    endtask

    task automatic send_bin(input logic [31:0] v, input logic sof);
        logic ok;
        mag_in = v; mag_sof = sof; mag_valid = 1'b1;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk); ok = mag_ready;
            @(posedge clk); #1;
            if (ok) return;
        end
        checks++; failures++;
        $display("FAIL send_timeout got=no_accept exp=accept");
    endtask

    task automatic end_stream();
        mag_valid = 1'b0; mag_sof = 1'b0;
    endtask

    task automatic wait_bands(input int n);
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (cap_out.size() >= n && !band_valid) return;
        end
        checks++; failures++;
        $display("FAIL wait_bands got=%0d exp=%0d", cap_out.size(), n);
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks += 6;
        if (mag_ready !== 1'b1)  begin failures++; $display("FAIL reset_mag_ready got=%b exp=1", mag_ready); end
        if (band_valid !== 1'b0) begin failures++; $display("FAIL reset_band_valid got=%b exp=0", band_valid); end
        if (band_out !== 32'h0)  begin failures++; $display("FAIL reset_band_out got=%h exp=0", band_out); end
        if (band_idx !== 4'h0)   begin failures++; $display("FAIL reset_band_idx got=%0d exp=0", band_idx); end
        if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
        if (overflow !== 1'b0)   begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_all_ones();
        ready_mode = 1;
        pulse_reset();
        for (int i = 0; i < 256; i++) send_bin(32'd1, i == 0);
        end_stream();
        wait_bands(16);
        checks++;
        if (cap_out.size() != 16) begin failures++; $display("FAIL ones_count got=%0d exp=16", cap_out.size()); end
        for (int k = 0; k < 16 && k < cap_out.size(); k++) begin
            checks++;
            if (cap_out[k] !== 32'd16 || cap_idx[k] !== 4'(k)) begin
                failures++; $display("FAIL ones_band%0d got=%0d/%0d exp=16/%0d", k, cap_out[k], cap_idx[k], k);
            end
        end
        checks++;
        if (fd_cnt != 1) begin failures++; $display("FAIL ones_frame_done got=%0d exp=1", fd_cnt); end
    endtask

    task automatic test_ramp_stall();
        ready_mode = 0;
        pulse_reset();
        for (int i = 0; i < 256; i++) begin
            send_bin(32'(i), i == 0);
            if (i == 14) begin
                checks++;
                if (band_valid !== 1'b0) begin failures++; $display("FAIL latency_early got=%b exp=0", band_valid); end
            end
            if (i == 15) begin
                checks++;
                if (band_valid !== 1'b1 || band_out !== 32'd120 || band_idx !== 4'd0) begin
                    failures++; $display("FAIL latency_first got=%b/%0d/%0d exp=1/120/0", band_valid, band_out, band_idx);
                end
            end
        end
        end_stream();
        repeat (3) begin
            @(negedge clk); checks++;
            if (mag_ready !== 1'b0) begin failures++; $display("FAIL drain_full_ready got=%b exp=0", mag_ready); end
        end
        @(posedge clk); #1;
        ready_mode = 1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (!band_valid) break;
            checks++;
            if (mag_ready !== 1'b0) begin failures++; $display("FAIL drain_ready got=%b exp=0", mag_ready); end
        end
        repeat (3) @(negedge clk);
        checks++;
        if (mag_ready !== 1'b1) begin failures++; $display("FAIL drain_idle_ready got=%b exp=1", mag_ready); end
        wait_bands(16);
        checks++;
        if (cap_out.size() != 16) begin failures++; $display("FAIL ramp_count got=%0d exp=16", cap_out.size()); end
        for (int k = 0; k < 16 && k < cap_out.size(); k++) begin
            checks++;
            if (cap_out[k] !== 32'(256 * k + 120) || cap_idx[k] !== 4'(k)) begin
                failures++; $display("FAIL ramp_band%0d got=%0d/%0d exp=%0d/%0d", k, cap_out[k], cap_idx[k], 256 * k + 120, k);
            end
        end
        checks++;
        if (fd_cnt != 1) begin failures++; $display("FAIL ramp_frame_done got=%0d exp=1", fd_cnt); end
    endtask

    task automatic test_sof_restart();
        logic [31:0] ev;
        int ei;
        ready_mode = 1;
        pulse_reset();
        for (int i = 0; i < 40; i++) send_bin(32'd1, i == 0);
        for (int i = 0; i < 256; i++) send_bin(32'd2, i == 0);
        end_stream();
        wait_bands(18);
        checks++;
        if (cap_out.size() != 18) begin failures++; $display("FAIL sof_count got=%0d exp=18", cap_out.size()); end
        for (int k = 0; k < 18 && k < cap_out.size(); k++) begin
            ev = (k < 2) ? 32'd16 : 32'd32;
            ei = (k < 2) ? k : k - 2;
            checks++;
            if (cap_out[k] !== ev || cap_idx[k] !== 4'(ei)) begin
                failures++; $display("FAIL sof_band%0d got=%0d/%0d exp=%0d/%0d", k, cap_out[k], cap_idx[k], ev, ei);
            end
        end
        checks++;
        if (fd_cnt != 1) begin failures++; $display("FAIL sof_frame_done got=%0d exp=1", fd_cnt); end
    endtask

    task automatic test_random_handshake();
        ready_mode = 2;
        pulse_reset();
        for (int i = 0; i < 256; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                end_stream();
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            send_bin(32'(i), i == 0);
        end
        end_stream();
        wait_bands(16);
        checks++;
        if (cap_out.size() != 16) begin failures++; $display("FAIL rand_count got=%0d exp=16", cap_out.size()); end
        for (int k = 0; k < 16 && k < cap_out.size(); k++) begin
            checks++;
            if (cap_out[k] !== 32'(256 * k + 120) || cap_idx[k] !== 4'(k)) begin
                failures++; $display("FAIL rand_band%0d got=%0d/%0d exp=%0d/%0d", k, cap_out[k], cap_idx[k], 256 * k + 120, k);
            end
        end
        checks++;
        if (fd_cnt != 1) begin failures++; $display("FAIL rand_frame_done got=%0d exp=1", fd_cnt); end
        @(posedge clk); #1;
        ready_mode = 1;
    endtask

    task automatic test_overflow();
        logic [31:0] v;
        ready_mode = 1;
        pulse_reset();
        for (int i = 0; i < 256; i++) begin
            v = (i < 2) ? 32'hFFFF_FFF0 : 32'h0;
            send_bin(v, i == 0);
        end
        end_stream();
        wait_bands(16);
        checks++;
        if (cap_out.size() != 16) begin failures++; $display("FAIL ovf_count got=%0d exp=16", cap_out.size()); end
        for (int k = 0; k < 16 && k < cap_out.size(); k++) begin
            v = (k == 0) ? 32'hFFFF_FFFF : 32'h0;
            checks++;
            if (cap_out[k] !== v) begin failures++; $display("FAIL ovf_band%0d got=%h exp=%h", k, cap_out[k], v); end
        end
        repeat (5) @(negedge clk);
        checks++;
        if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_reset_clear got=%b exp=0", overflow); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset_midframe();
        ready_mode = 1;
        pulse_reset();
        for (int i = 0; i < 100; i++) send_bin(32'd1, i == 0);
        rst = 1'b1; mag_valid = 1'b0; mag_sof = 1'b0;
        checks++;
        if (cap_out.size() != 6) begin failures++; $display("FAIL mid_pre_count got=%0d exp=6", cap_out.size()); end
        @(negedge clk);
        checks += 5;
        if (band_valid !== 1'b0) begin failures++; $display("FAIL mid_band_valid got=%b exp=0", band_valid); end
        if (band_out !== 32'h0)  begin failures++; $display("FAIL mid_band_out got=%h exp=0", band_out); end
        if (band_idx !== 4'h0)   begin failures++; $display("FAIL mid_band_idx got=%0d exp=0", band_idx); end
        if (mag_ready !== 1'b1)  begin failures++; $display("FAIL mid_mag_ready got=%b exp=1", mag_ready); end
        if (frame_done !== 1'b0) begin failures++; $display("FAIL mid_frame_done got=%b exp=0", frame_done); end
        @(posedge clk); #1;
        rst = 1'b0;
        cap_out.delete(); cap_idx.delete(); fd_cnt = 0;
        repeat (5) @(negedge clk);
        checks++;
        if (band_valid !== 1'b0) begin failures++; $display("FAIL mid_idle_valid got=%b exp=0", band_valid); end
        @(posedge clk); #1;
        for (int i = 0; i < 256; i++) send_bin(32'd3, i == 0);
        end_stream();
        wait_bands(16);
        checks++;
        if (cap_out.size() != 16) begin failures++; $display("FAIL mid_count got=%0d exp=16", cap_out.size()); end
        for (int k = 0; k < 16 && k < cap_out.size(); k++) begin
            checks++;
            if (cap_out[k] !== 32'd48 || cap_idx[k] !== 4'(k)) begin
                failures++; $display("FAIL mid_band%0d got=%0d/%0d exp=48/%0d", k, cap_out[k], cap_idx[k], k);
            end
        end
        checks++;
        if (fd_cnt != 1) begin failures++; $display("FAIL mid_frame_done got=%0d exp=1", fd_cnt); end
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_ramp_stall();
        test_sof_restart();
        test_random_handshake();
        test_overflow();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
